// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the M-extension sequencer state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// 64-bit accumulator for unsigned shift-add multiply and restoring divide,
// one step per cycle. Multiply: {hi,lo} = {partial, multiplier}; divide: {rem, quotient}.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [XLEN-1:0]   i_lo_init,
  input  logic [XLEN-1:0]   i_b,
  input  logic              i_step_mul,
  input  logic              i_step_div,
  output logic [2*XLEN-1:0] o_acc_next
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;

  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;

  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  // The shifted remainder is XLEN+1 bits wide; its top bit alone means it exceeds the divisor.
  assign w_ge   = r_acc[2*XLEN-1] | (r_acc[2*XLEN-2:XLEN-1] >= r_b);
  assign w_diff = r_acc[2*XLEN-2:XLEN-1] - r_b;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    o_acc_next = r_acc;
    if (i_step_mul) begin
      o_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end else if (i_step_div) begin
      o_acc_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                        : {r_acc[2*XLEN-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_lo_init};
      r_b   <= i_b;
    end else if (i_step_mul || i_step_div) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M iterative multiply/divide sequencer beside the EX stage: decodes M-ops,
// stalls the front of the pipe while iterating and presents the result for one cycle.
module ex_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ex,
  input  logic [6:0]      opcode_ex,
  input  logic [2:0]      func3_ex,
  input  logic [6:0]      func7_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic            flush_ex,
  output logic            stall_ex,
  output logic            md_sel_ex,
  output logic [XLEN-1:0] md_result_ex,
  output logic            busy_ex
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_md_op, w_start, w_is_div, w_last, w_iterating;
  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_result;
  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_iter_result;

  assign w_md_op  = valid_ex & (opcode_ex == OPCODE_OP) & (func7_ex == FUNCT7_MULDIV);
  assign w_start  = (r_state == IDLE) & w_md_op & ~flush_ex;
  assign w_is_div = func3_ex[2];

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (func3_ex)
      F3_MULH, F3_DIV, F3_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      F3_MULHSU: w_a_signed = 1'b1;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: ;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_signed & rs1_data_ex[XLEN-1];
  assign w_b_neg = w_b_signed & rs2_data_ex[XLEN-1];
  assign w_a_mag = w_a_neg ? -rs1_data_ex : rs1_data_ex;
  assign w_b_mag = w_b_neg ? -rs2_data_ex : rs2_data_ex;

  assign w_div_zero = w_is_div & (rs2_data_ex == '0);
  assign w_div_ovf  = ((func3_ex == F3_DIV) | (func3_ex == F3_REM)) &
                      (rs1_data_ex == INT_MIN) & (rs2_data_ex == '1);
  assign w_fast     = w_div_zero | w_div_ovf;
  // func3[1] selects the remainder flavour of the divide group.
  assign w_fast_result = w_div_zero ? (func3_ex[1] ? rs1_data_ex : '1)
                                    : (func3_ex[1] ? '0 : INT_MIN);

  assign w_iterating = (r_state == MUL) | (r_state == DIV);
  assign w_last      = (r_cnt == CNT_W'(ITER - 1));

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start & ~w_fast),
    .i_lo_init  (w_a_mag),
    .i_b        (w_b_mag),
    .i_step_mul ((r_state == MUL) & ~flush_ex),
    .i_step_div ((r_state == DIV) & ~flush_ex),
    .o_acc_next (w_acc_next)
  );

  // Sign fix is applied to the post-step value so the result lands on entry to DONE.
  assign w_prod = r_neg_res ? -w_acc_next : w_acc_next;
  assign w_quo  = r_neg_res ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_iter_result = w_prod[2*XLEN-1:XLEN];
    if (r_state == DIV) begin
      w_iter_result = r_func3[1] ? w_rem : w_quo;
    end else if (r_func3 == F3_MUL) begin
      w_iter_result = w_prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_start) w_state_next = w_fast ? DONE : (w_is_div ? DIV : MUL);
      MUL, DIV: if (w_last)  w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
    if (flush_ex) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_func3   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_start) begin
        r_func3   <= func3_ex;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        if (w_fast) begin
          r_result <= w_fast_result;
        end
      end
      if (w_iterating && !flush_ex && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_iterating && !flush_ex && w_last) begin
        r_result <= w_iter_result;
      end
    end
  end

  assign stall_ex     = w_md_op & ~flush_ex & (r_state != DONE);
  assign md_sel_ex    = (r_state == DONE);
  assign busy_ex      = (r_state != IDLE);
  assign md_result_ex = r_result;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: hand-computed results, latency, flush and reset behaviour.
module tb_ex_muldiv_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex;
  logic [6:0]  opcode_ex;
  logic [2:0]  func3_ex;
  logic [6:0]  func7_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic        flush_ex;
  logic        stall_ex;
  logic        md_sel_ex;
  logic [31:0] md_result_ex;
  logic        busy_ex;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_ex     (valid_ex),
    .opcode_ex    (opcode_ex),
    .func3_ex     (func3_ex),
    .func7_ex     (func7_ex),
    .rs1_data_ex  (rs1_data_ex),
    .rs2_data_ex  (rs2_data_ex),
    .flush_ex     (flush_ex),
    .stall_ex     (stall_ex),
    .md_sel_ex    (md_sel_ex),
    .md_result_ex (md_result_ex),
    .busy_ex      (busy_ex)
  );

  // Entered 1 time unit after a rising edge; holds the M-op in EX until md_sel_ex
  // is seen, then removes it. Returns 1 time unit after the edge that retires it.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int nstall, output int sel_cyc);
    int  cyc;
    bit  done;
    res = '0; nstall = 0; sel_cyc = -1; done = 0; cyc = 0;
    valid_ex = 1'b1; opcode_ex = OPCODE_OP; func7_ex = FUNCT7_MULDIV;
    func3_ex = f3; rs1_data_ex = a; rs2_data_ex = b;
    while (!done && cyc < 100) begin
      #1;
      if (stall_ex) nstall++;
      if (md_sel_ex) begin
        res = md_result_ex; sel_cyc = cyc; done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid_ex = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({stall_ex, md_sel_ex, busy_ex} !== 3'b000 || md_result_ex !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b sel=%b busy=%b res=%h, want 0 0 0 00000000",
               stall_ex, md_sel_ex, busy_ex, md_result_ex);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_ex !== 1'b0 || md_sel_ex !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b sel=%b, want 0 0", busy_ex, md_sel_ex);
    end
    // Bubble carrying an M-op encoding, then a live non-M op: neither may start the FSM.
    opcode_ex = OPCODE_OP; func7_ex = FUNCT7_MULDIV; func3_ex = F3_DIV;
    rs1_data_ex = 32'd10; rs2_data_ex = 32'd3; valid_ex = 1'b0;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL bubble_stall: got %b want 0", stall_ex);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_ex !== 1'b0) begin
      errors++; $display("FAIL bubble_busy: got %b want 0", busy_ex);
    end
    valid_ex = 1'b1; func7_ex = 7'b0000000;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL non_m_stall: got %b want 0", stall_ex);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_ex !== 1'b0) begin
      errors++; $display("FAIL non_m_busy: got %b want 0", busy_ex);
    end
    valid_ex = 1'b0;
  endtask

  task automatic test_mul_group();
    logic [2:0]  f3  [4] = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU};
    logic [31:0] a   [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b   [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] res;
    int          nst, sel;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], res, nst, sel);
      checks++;
      if (res !== exp[i]) begin
        errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]);
      end
      checks++;
      if (nst !== 33 || sel !== 33) begin
        errors++; $display("FAIL mul_latency[%0d]: got stall=%0d sel_at=%0d want 33 33", i, nst, sel);
      end
    end
    #1;
    checks++;
    if (md_sel_ex !== 1'b0 || busy_ex !== 1'b0) begin
      errors++; $display("FAIL mul_single_pulse: got sel=%b busy=%b want 0 0", md_sel_ex, busy_ex);
    end
  endtask

  task automatic test_div_group();
    logic [2:0]  f3  [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] a   [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2};
    logic [31:0] res;
    int          nst, sel;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], res, nst, sel);
      checks++;
      if (res !== exp[i]) begin
        errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]);
      end
      checks++;
      if (nst !== 33 || sel !== 33) begin
        errors++; $display("FAIL div_latency[%0d]: got stall=%0d sel_at=%0d want 33 33", i, nst, sel);
      end
    end
  endtask

  task automatic test_fast_cases();
    logic [2:0]  f3  [4] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h00000000};
    logic [31:0] res;
    int          nst, sel;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], res, nst, sel);
      checks++;
      if (res !== exp[i]) begin
        errors++; $display("FAIL fast_result[%0d]: got %h want %h", i, res, exp[i]);
      end
      checks++;
      if (nst !== 1 || sel !== 1) begin
        errors++; $display("FAIL fast_latency[%0d]: got stall=%0d sel_at=%0d want 1 1", i, nst, sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2;
    int          nst1, sel1, nst2, sel2;
    do_op(F3_DIVU, 32'd1000, 32'd10, res1, nst1, sel1);
    do_op(F3_MUL, 32'd12, 32'd12, res2, nst2, sel2);
    checks++;
    if (res1 !== 32'd100 || res2 !== 32'd144) begin
      errors++; $display("FAIL b2b_results: got %0d %0d want 100 144", res1, res2);
    end
    checks++;
    if (sel1 !== 33 || sel2 !== 33 || nst2 !== 33) begin
      errors++; $display("FAIL b2b_latency: got sel=%0d/%0d stall2=%0d want 33/33 33", sel1, sel2, nst2);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          nst, sel, pulses;
    // Flush coinciding with the M-op in IDLE: nothing is captured.
    valid_ex = 1'b1; opcode_ex = OPCODE_OP; func7_ex = FUNCT7_MULDIV; func3_ex = F3_DIV;
    rs1_data_ex = 32'd100; rs2_data_ex = 32'd7; flush_ex = 1'b1;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall: got %b want 0", stall_ex);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_ex !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy: got %b want 0", busy_ex);
    end
    flush_ex = 1'b0;
    // Accept now (cycle T); iteration 10 is cycle T+11.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (stall_ex !== 1'b1 || busy_ex !== 1'b1) begin
      errors++; $display("FAIL flush_pre: got stall=%b busy=%b want 1 1", stall_ex, busy_ex);
    end
    flush_ex = 1'b1;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL flush_iter_stall: got %b want 0", stall_ex);
    end
    @(posedge clk); #1;
    flush_ex = 1'b0; valid_ex = 1'b0;
    checks++;
    if (busy_ex !== 1'b0) begin
      errors++; $display("FAIL flush_iter_busy: got %b want 0", busy_ex);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_sel_ex) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL flush_no_sel: got %0d pulses want 0", pulses);
    end
    do_op(F3_MUL, 32'd6, 32'd7, res, nst, sel);
    checks++;
    if (res !== 32'd42 || sel !== 33) begin
      errors++; $display("FAIL post_flush_mul: got %0d at %0d want 42 at 33", res, sel);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          nst, sel;
    valid_ex = 1'b1; opcode_ex = OPCODE_OP; func7_ex = FUNCT7_MULDIV; func3_ex = F3_MUL;
    rs1_data_ex = 32'd123; rs2_data_ex = 32'd456;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy_ex !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: busy got %b want 1", busy_ex);
    end
    rst_n = 1'b0; valid_ex = 1'b0;
    #1;
    checks++;
    if ({stall_ex, md_sel_ex, busy_ex} !== 3'b000 || md_result_ex !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got stall=%b sel=%b busy=%b res=%h, want 0 0 0 00000000",
               stall_ex, md_sel_ex, busy_ex, md_result_ex);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(F3_DIVU, 32'd9, 32'd3, res, nst, sel);
    checks++;
    if (res !== 32'd3 || sel !== 33 || nst !== 33) begin
      errors++; $display("FAIL post_reset_divu: got %0d sel_at=%0d stall=%0d want 3 33 33", res, sel, nst);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_ex = 1'b0; opcode_ex = '0; func3_ex = '0; func7_ex = '0;
    rs1_data_ex = '0; rs2_data_ex = '0; flush_ex = 1'b0;
    test_reset();
    test_mul_group();
    test_div_group();
    test_fast_cases();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
